// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating frame accumulator for 7-bit multiplier products.
// Sums COUNT accepted beats per frame and presents the sum through a valid/ready handshake.
module mac_accumulator #(
   parameter int COUNT = 8,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [6:0]       prod,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [ACC_W-1:0] acc_out,
   output logic [7:0]       beat_cnt,
   output logic             overflow
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state;
   logic accept;
   logic last;
   logic [ACC_W:0] sum;
   logic [7:0] next_cnt;
   assign in_ready = state != DONE;
   assign accept   = in_valid && in_ready;
   // one extra bit catches the carry that signals saturation
   assign sum      = (ACC_W+1)'(acc_out) + (ACC_W+1)'(prod);
   assign next_cnt = beat_cnt + 8'd1;
   assign last     = next_cnt == 8'(COUNT);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc_out   <= '0;
         beat_cnt  <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         acc_out   <= '0;
         beat_cnt  <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               acc_out   <= ACC_W'(prod);
               beat_cnt  <= 8'd1;
               overflow  <= 1'b0;
               state     <= COUNT == 1 ? DONE : ACCUM;
               out_valid <= COUNT == 1;
            end
            ACCUM: if (accept) begin
               acc_out  <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
               overflow <= overflow | sum[ACC_W];
               beat_cnt <= next_cnt;
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               acc_out   <= '0;
               beat_cnt  <= '0;
               overflow  <= 1'b0;
               out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed vectors for three parameterisations of mac_accumulator.
module tb_mac_accumulator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic [6:0] prod = '0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   int tests = 0;
   int fails = 0;

   logic a_ir, a_ov, a_ovf, b_ir, b_ov, b_ovf, c_ir, c_ov, c_ovf;
   logic [11:0] a_acc, c_acc;
   logic [6:0] b_acc;
   logic [7:0] a_cnt, b_cnt, c_cnt;

   always #5 clk = ~clk;

   mac_accumulator #(.COUNT(8), .ACC_W(12)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod(prod), .in_valid(in_valid),
      .in_ready(a_ir), .out_ready(out_ready), .out_valid(a_ov), .acc_out(a_acc),
      .beat_cnt(a_cnt), .overflow(a_ovf));
   mac_accumulator #(.COUNT(4), .ACC_W(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod(prod), .in_valid(in_valid),
      .in_ready(b_ir), .out_ready(out_ready), .out_valid(b_ov), .acc_out(b_acc),
      .beat_cnt(b_cnt), .overflow(b_ovf));
   mac_accumulator #(.COUNT(1), .ACC_W(12)) dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear), .prod(prod), .in_valid(in_valid),
      .in_ready(c_ir), .out_ready(out_ready), .out_valid(c_ov), .acc_out(c_acc),
      .beat_cnt(c_cnt), .overflow(c_ovf));

   typedef struct {
      logic vld;
      logic [6:0] p;
      logic ordy;
      logic e_ir;
      logic e_ov;
      int e_acc;
      int e_cnt;
      logic e_ovf;
   } vec_t;
   vec_t v[$];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   task automatic expect_dut(input int sel, input string tag, input logic ir, input logic ov,
                             input int acc, input int cnt, input logic ovf);
      logic [31:0] r_ir, r_ov, r_acc, r_cnt, r_ovf;
      r_ir  = sel == 0 ? 32'(a_ir)  : sel == 1 ? 32'(b_ir)  : 32'(c_ir);
      r_ov  = sel == 0 ? 32'(a_ov)  : sel == 1 ? 32'(b_ov)  : 32'(c_ov);
      r_acc = sel == 0 ? 32'(a_acc) : sel == 1 ? 32'(b_acc) : 32'(c_acc);
      r_cnt = sel == 0 ? 32'(a_cnt) : sel == 1 ? 32'(b_cnt) : 32'(c_cnt);
      r_ovf = sel == 0 ? 32'(a_ovf) : sel == 1 ? 32'(b_ovf) : 32'(c_ovf);
      chk({tag, ".in_ready"}, r_ir, 32'(ir));
      chk({tag, ".out_valid"}, r_ov, 32'(ov));
      chk({tag, ".acc_out"}, r_acc, acc);
      chk({tag, ".beat_cnt"}, r_cnt, cnt);
      chk({tag, ".overflow"}, r_ovf, 32'(ovf));
   endtask

   task automatic drive(input logic vld, input logic [6:0] p, input logic ordy, input logic clr);
      in_valid = vld;
      prod = p;
      out_ready = ordy;
      clear = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      clear = 1'b0;
      prod = '0;
      #2;
      for (int s = 0; s < 3; s++) expect_dut(s, {tag, ".rst"}, 1'b1, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int prods[8] = '{6, 14, 0, 105, 21, 45, 3, 8};
      int sums[8]  = '{6, 20, 20, 125, 146, 191, 194, 202};
      int fill[8]  = '{10, 10, 10, 10, 5, 5, 0, 0};
      vec_t r;
      // frame with in_valid held high, then the output handshake
      for (int i = 0; i < 8; i++) begin
         r = '{1'b1, 7'(prods[i]), 1'b0, i != 7, i == 7, sums[i], i + 1, 1'b0};
         v.push_back(r);
      end
      r = '{1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
      v.push_back(r);
      // same frame with gaps: idle rows carry junk that must be ignored
      for (int i = 0; i < 8; i++) begin
         r = '{1'b1, 7'(prods[i]), 1'b0, i != 7, i == 7, sums[i], i + 1, 1'b0};
         v.push_back(r);
         r = '{1'b0, 7'd99, 1'b0, i != 7, i == 7, sums[i], i + 1, 1'b0};
         v.push_back(r);
      end
      v.push_back(r);
      r = '{1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
      v.push_back(r);

      do_reset("init");
      for (int i = 0; i < v.size(); i++) begin
         drive(v[i].vld, v[i].p, v[i].ordy, 1'b0);
         expect_dut(0, $sformatf("vec%0d", i), v[i].e_ir, v[i].e_ov, v[i].e_acc, v[i].e_cnt, v[i].e_ovf);
      end

      do_reset("sat");
      drive(1'b1, 7'd105, 1'b0, 1'b0);
      expect_dut(1, "sat.b1", 1'b1, 1'b0, 105, 1, 1'b0);
      drive(1'b1, 7'd105, 1'b0, 1'b0);
      expect_dut(1, "sat.b2", 1'b1, 1'b0, 127, 2, 1'b1);
      drive(1'b1, 7'd10, 1'b0, 1'b0);
      expect_dut(1, "sat.b3", 1'b1, 1'b0, 127, 3, 1'b1);
      drive(1'b1, 7'd1, 1'b0, 1'b0);
      expect_dut(1, "sat.b4", 1'b0, 1'b1, 127, 4, 1'b1);
      drive(1'b0, 7'd0, 1'b1, 1'b0);
      expect_dut(1, "sat.hs", 1'b1, 1'b0, 0, 0, 1'b0);
      // frame sum exactly at max must not flag overflow
      drive(1'b1, 7'd127, 1'b0, 1'b0);
      drive(1'b1, 7'd0, 1'b0, 1'b0);
      drive(1'b1, 7'd0, 1'b0, 1'b0);
      drive(1'b1, 7'd0, 1'b0, 1'b0);
      expect_dut(1, "sat.edge", 1'b0, 1'b1, 127, 4, 1'b0);

      do_reset("bp");
      for (int i = 0; i < 8; i++) drive(1'b1, 7'(fill[i]), 1'b0, 1'b0);
      expect_dut(0, "bp.done", 1'b0, 1'b1, 50, 8, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 7'd99, 1'b0, 1'b0);
         expect_dut(0, $sformatf("bp.hold%0d", i), 1'b0, 1'b1, 50, 8, 1'b0);
      end
      drive(1'b1, 7'd99, 1'b1, 1'b0);
      expect_dut(0, "bp.hs", 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b0);
      expect_dut(0, "bp.idle", 1'b1, 1'b0, 0, 0, 1'b0);

      do_reset("clr");
      for (int i = 0; i < 3; i++) drive(1'b1, 7'd10, 1'b0, 1'b0);
      expect_dut(0, "clr.pre", 1'b1, 1'b0, 30, 3, 1'b0);
      drive(1'b1, 7'd7, 1'b0, 1'b1);
      expect_dut(0, "clr.abort", 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b0);
      expect_dut(0, "clr.after", 1'b1, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b1, 7'd1, 1'b0, 1'b0);
      expect_dut(0, "clr.full", 1'b0, 1'b1, 8, 8, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 1'b1);
      expect_dut(0, "clr.done", 1'b1, 1'b0, 0, 0, 1'b0);

      do_reset("one");
      drive(1'b1, 7'd42, 1'b0, 1'b0);
      expect_dut(2, "one.beat", 1'b0, 1'b1, 42, 1, 1'b0);
      drive(1'b1, 7'd5, 1'b0, 1'b0);
      expect_dut(2, "one.hold", 1'b0, 1'b1, 42, 1, 1'b0);
      drive(1'b0, 7'd0, 1'b1, 1'b0);
      expect_dut(2, "one.hs", 1'b1, 1'b0, 0, 0, 1'b0);

      do_reset("arst");
      for (int i = 0; i < 3; i++) drive(1'b1, 7'd20, 1'b0, 1'b0);
      expect_dut(0, "arst.pre", 1'b1, 1'b0, 60, 3, 1'b0);
      #2 rst_n = 1'b0;
      #1 expect_dut(0, "arst.mid", 1'b1, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) drive(1'b1, 7'd20, 1'b0, 1'b0);
      expect_dut(0, "arst.full", 1'b0, 1'b1, 160, 8, 1'b0);
      #2 rst_n = 1'b0;
      #1 expect_dut(0, "arst.done", 1'b1, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 7'd0, 1'b0, 1'b0);
      expect_dut(0, "arst.post", 1'b1, 1'b0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
